// File: rtl/hex_display_scanner.sv
// hex_display_scanner: time-multiplexed N-digit hex 7-segment driver.
// A pending shadow register is copied to the active register on frame
// boundaries only, so the displayed digits never tear. Segment/enable
// polarity is selectable for common-anode or common-cathode banks.
module hex_display_scanner #(
    parameter int DIGITS     = 6,
    parameter int SCAN_DIV   = 50000,
    parameter int GUARD      = 1,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [7:0]            seg_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_tick,
    output logic                  busy
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic POL = (ACTIVE_LOW != 0);
    localparam logic [7:0] SEG_OFF = {8{POL}};
    localparam logic [DIGITS-1:0] EN_OFF = {DIGITS{POL}};

    // Pending (shadow) and active display state
    logic [4*DIGITS-1:0] pend_value_reg;
    logic [DIGITS-1:0]   pend_dp_reg;
    logic                pend_blz_reg;
    logic                pend_valid_reg;
    logic [4*DIGITS-1:0] act_value_reg;
    logic [DIGITS-1:0]   act_dp_reg;
    logic                act_blz_reg;

    // Scan position
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [IDX_W-1:0] idx_reg, idx_next;

    // Registered outputs
    logic [7:0]        seg_reg, seg_next;
    logic [DIGITS-1:0] en_reg, en_next;
    logic              tick_reg;

    logic slot_end;
    logic frame_end;
    logic in_guard;

    logic [3:0]        nib [DIGITS];
    logic [DIGITS-1:0] blank_mask;

    assign slot_end  = (cnt_reg == CNT_LAST);
    assign frame_end = slot_end && (idx_reg == IDX_LAST);

    // Guard window at the start of each slot keeps all digits dark to avoid ghosting
    generate
        if (GUARD > 0) begin : g_guard
            assign in_guard = (cnt_reg < CNT_W'(GUARD));
        end else begin : g_noguard
            assign in_guard = 1'b0;
        end
    endgenerate

    // Per-digit nibble split and leading-zero detection; digit 0 always shows
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nib[gi] = act_value_reg[4*gi +: 4];
            if (gi == 0) begin : g_lsd
                assign blank_mask[gi] = 1'b0;
            end else begin : g_upper
                assign blank_mask[gi] = act_blz_reg &&
                                        (act_value_reg[4*DIGITS-1:4*gi] == '0);
            end
        end
    endgenerate

    // Hex nibble to logical segment pattern {G,F,E,D,C,B,A}
    function automatic logic [6:0] glyph_f(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b0111111;
            4'h1:    g = 7'b0000110;
            4'h2:    g = 7'b1011011;
            4'h3:    g = 7'b1001111;
            4'h4:    g = 7'b1100110;
            4'h5:    g = 7'b1101101;
            4'h6:    g = 7'b1111101;
            4'h7:    g = 7'b0000111;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1101111;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b1111100;
            4'hC:    g = 7'b0111001;
            4'hD:    g = 7'b1011110;
            4'hE:    g = 7'b1111001;
            default: g = 7'b1110001;
        endcase
        return g;
    endfunction

    // Slot counter and digit index advance
    always_comb begin
        cnt_next = cnt_reg + CNT_W'(1);
        idx_next = idx_reg;
        if (slot_end) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + IDX_W'(1);
        end
    end

    // Decode of the current slot into physical segment and enable patterns
    always_comb begin
        logic [7:0]        seg_logic;
        logic [DIGITS-1:0] en_logic;
        seg_logic = {act_dp_reg[idx_reg],
                     blank_mask[idx_reg] ? 7'd0 : glyph_f(nib[idx_reg])};
        en_logic  = DIGITS'(1) << idx_reg;
        if (in_guard) begin
            seg_logic = '0;
            en_logic  = '0;
        end
        seg_next = seg_logic ^ SEG_OFF;
        en_next  = en_logic ^ EN_OFF;
    end

    // Scan position and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            idx_reg  <= '0;
            seg_reg  <= SEG_OFF;
            en_reg   <= EN_OFF;
            tick_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            idx_reg  <= idx_next;
            seg_reg  <= seg_next;
            en_reg   <= en_next;
            tick_reg <= frame_end;
        end
    end

    // Pending capture; a load on the boundary cycle lands after the transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value_reg <= '0;
            pend_dp_reg    <= '0;
            pend_blz_reg   <= 1'b0;
            pend_valid_reg <= 1'b0;
        end else if (load) begin
            pend_value_reg <= value;
            pend_dp_reg    <= dp_in;
            pend_blz_reg   <= blank_lz;
            pend_valid_reg <= 1'b1;
        end else if (frame_end) begin
            pend_valid_reg <= 1'b0;
        end
    end

    // Active value only changes on a frame boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            act_value_reg <= '0;
            act_dp_reg    <= '0;
            act_blz_reg   <= 1'b0;
        end else if (frame_end && pend_valid_reg) begin
            act_value_reg <= pend_value_reg;
            act_dp_reg    <= pend_dp_reg;
            act_blz_reg   <= pend_blz_reg;
        end
    end

    assign seg_out    = seg_reg;
    assign digit_en   = en_reg;
    assign frame_tick = tick_reg;
    assign busy       = pend_valid_reg;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner: two instances (common-anode with guard,
// common-cathode without guard) share stimulus; a frame-level model checks
// every cycle, plus a vector table and hand sequences for corner cases.
module tb_hex_display_scanner;

    localparam int D = 4;
    localparam int S = 4;
    localparam int FRAME = D * S;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic        blank_lz = 1'b0;

    logic [7:0] seg_al, seg_ah;
    logic [3:0] en_al, en_ah;
    logic       tick_al, tick_ah, busy_al, busy_ah;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    hex_display_scanner #(.DIGITS(D), .SCAN_DIV(S), .GUARD(1), .ACTIVE_LOW(1)) dut_al (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg_out(seg_al), .digit_en(en_al),
        .frame_tick(tick_al), .busy(busy_al)
    );

    hex_display_scanner #(.DIGITS(D), .SCAN_DIV(S), .GUARD(0), .ACTIVE_LOW(0)) dut_ah (
        .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
        .blank_lz(blank_lz), .seg_out(seg_ah), .digit_en(en_ah),
        .frame_tick(tick_ah), .busy(busy_ah)
    );

    // Reference model state (frame-level view)
    logic [6:0]  glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [15:0] m_pv, m_av;
    logic [3:0]  m_pd, m_ad;
    logic        m_pb, m_ab, m_pvalid;
    int          m_n;
    int          last_p;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {seg, en} for a frame position p given guard length and polarity
    function automatic logic [11:0] model_out(input int p, input int guard, input bit al);
        int c, i;
        logic [7:0]  s;
        logic [3:0]  e;
        logic [15:0] rest;
        c = p % S;
        i = p / S;
        s = '0;
        e = '0;
        if (c >= guard) begin
            rest = m_av >> (4 * i);
            e = 4'(1 << i);
            s = {m_ad[i], (m_ab && i != 0 && rest == 16'h0) ? 7'h00 : glyph_tab[rest[3:0]]};
        end
        if (al) begin
            s = ~s;
            e = ~e;
        end
        return {s, e};
    endfunction

    // One clock: advance the model with the inputs seen at the edge, then compare
    task automatic tick();
        logic [11:0] o_al, o_ah;
        logic        et;
        int          p;
        @(posedge clk);
        if (rst) begin
            o_al = {8'hFF, 4'hF};
            o_ah = {8'h00, 4'h0};
            et = 1'b0;
            m_pv = '0; m_pd = '0; m_pb = 1'b0; m_pvalid = 1'b0;
            m_av = '0; m_ad = '0; m_ab = 1'b0;
            m_n = 0;
            last_p = -1;
        end else begin
            p = m_n % FRAME;
            o_al = model_out(p, 1, 1'b1);
            o_ah = model_out(p, 0, 1'b0);
            et = (p == FRAME - 1);
            if (et && m_pvalid) begin
                m_av = m_pv; m_ad = m_pd; m_ab = m_pb; m_pvalid = 1'b0;
            end
            if (load) begin
                m_pv = value; m_pd = dp_in; m_pb = blank_lz; m_pvalid = 1'b1;
            end
            m_n++;
            last_p = p;
        end
        #1;
        check("seg_al", 32'(seg_al), 32'(o_al[11:4]));
        check("en_al", 32'(en_al), 32'(o_al[3:0]));
        check("tick_al", 32'(tick_al), 32'(et));
        check("busy_al", 32'(busy_al), 32'(m_pvalid));
        check("seg_ah", 32'(seg_ah), 32'(o_ah[11:4]));
        check("en_ah", 32'(en_ah), 32'(o_ah[3:0]));
        check("tick_ah", 32'(tick_ah), 32'(et));
        check("busy_ah", 32'(busy_ah), 32'(m_pvalid));
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp, input logic blz);
        value = v; dp_in = dp; blank_lz = blz; load = 1'b1;
        $display("load value=%h dp=%b blank_lz=%0d at %0t", v, dp, blz, $time);
        tick();
        load = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (m_pvalid && n < 4 * FRAME) begin
            tick();
            n++;
        end
        check("idle_timeout", 32'(m_pvalid), 32'd0);
    endtask

    // Run until the output shows the last cycle of digit k's slot
    task automatic wait_slot_end(input int k);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 4 * FRAME && !found; n++) begin
            tick();
            if (last_p == k * S + S - 1) found = 1'b1;
        end
        check("slot_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_pos(input int pos);
        for (int n = 0; n < 2 * FRAME && (m_n % FRAME) != pos; n++) tick();
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  dp;
        logic        blz;
        int          k;
        logic [7:0]  al;
        logic [7:0]  ah;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int gap;
        bit seen;
        logic [15:0] rv;

        tbl[0]  = '{16'h12AF, 4'b0100, 1'b0, 0, 8'h8E, 8'h71};
        tbl[1]  = '{16'h12AF, 4'b0100, 1'b0, 1, 8'h88, 8'h77};
        tbl[2]  = '{16'h12AF, 4'b0100, 1'b0, 2, 8'h24, 8'hDB};
        tbl[3]  = '{16'h12AF, 4'b0100, 1'b0, 3, 8'hF9, 8'h06};
        tbl[4]  = '{16'h0050, 4'b0000, 1'b1, 3, 8'hFF, 8'h00};
        tbl[5]  = '{16'h0050, 4'b0000, 1'b1, 2, 8'hFF, 8'h00};
        tbl[6]  = '{16'h0050, 4'b0000, 1'b1, 1, 8'h92, 8'h6D};
        tbl[7]  = '{16'h0050, 4'b0000, 1'b1, 0, 8'hC0, 8'h3F};
        tbl[8]  = '{16'h0000, 4'b0000, 1'b1, 0, 8'hC0, 8'h3F};
        tbl[9]  = '{16'h0000, 4'b0000, 1'b1, 1, 8'hFF, 8'h00};
        tbl[10] = '{16'h0050, 4'b1000, 1'b1, 3, 8'h7F, 8'h80};
        tbl[11] = '{16'h0008, 4'b0000, 1'b0, 0, 8'h80, 8'h7F};

        // Reset held for 3 cycles, then release
        rst = 1'b1;
        repeat (3) tick();
        check("rst_seg", 32'(seg_al), 32'hFF);
        check("rst_en", 32'(en_al), 32'hF);
        check("rst_tick", 32'(tick_al), 32'd0);
        check("rst_busy", 32'(busy_al), 32'd0);
        rst = 1'b0;
        tick();
        check("first_guard_en", 32'(en_al), 32'hF);
        check("first_en_noguard", 32'(en_ah), 32'h1);
        check("first_seg_noguard", 32'(seg_ah), 32'h3F);
        tick();
        check("first_en", 32'(en_al), 32'hE);
        check("first_seg", 32'(seg_al), 32'hC0);

        // Vector table
        for (int r = 0; r < 12; r++) begin
            do_load(tbl[r].v, tbl[r].dp, tbl[r].blz);
            check("tbl_busy", 32'(busy_al), 32'd1);
            wait_idle();
            wait_slot_end(tbl[r].k);
            check("tbl_seg_al", 32'(seg_al), 32'(tbl[r].al));
            check("tbl_seg_ah", 32'(seg_ah), 32'(tbl[r].ah));
            check("tbl_en_al", 32'(en_al), 32'(4'(~(4'b0001 << tbl[r].k))));
            check("tbl_en_ah", 32'(en_ah), 32'(4'(4'b0001 << tbl[r].k)));
        end

        // Double load in one frame: only the second value appears
        wait_pos(2);
        do_load(16'h1111, 4'b0000, 1'b0);
        do_load(16'h2222, 4'b0000, 1'b0);
        wait_idle();
        wait_slot_end(0);
        check("dbl_seg", 32'(seg_al), 32'hA4);

        // frame_tick spacing
        seen = 1'b0;
        for (int n = 0; n < 2 * FRAME && !seen; n++) begin
            tick();
            seen = tick_al;
        end
        gap = 0;
        seen = 1'b0;
        for (int n = 0; n < 2 * FRAME && !seen; n++) begin
            tick();
            gap++;
            seen = tick_al;
        end
        check("tick_gap", 32'(gap), 32'(FRAME));

        // Load on the boundary cycle: old pending shown first, new one next frame
        wait_pos(5);
        do_load(16'h3333, 4'b0000, 1'b0);
        wait_pos(FRAME - 1);
        do_load(16'h4444, 4'b0000, 1'b0);
        check("coll_busy", 32'(busy_al), 32'd1);
        wait_slot_end(0);
        check("coll_old", 32'(seg_al), 32'hB0);
        wait_idle();
        wait_slot_end(0);
        check("coll_new", 32'(seg_al), 32'h99);

        // Reset mid-slot beats a simultaneous load and discards pending
        wait_pos(1);
        do_load(16'h5555, 4'b0000, 1'b0);
        tick();
        rst = 1'b1;
        load = 1'b1;
        value = 16'h6666;
        tick();
        check("mrst_seg_ah", 32'(seg_ah), 32'h00);
        check("mrst_en_ah", 32'(en_ah), 32'h0);
        check("mrst_seg_al", 32'(seg_al), 32'hFF);
        check("mrst_busy", 32'(busy_al), 32'd0);
        rst = 1'b0;
        load = 1'b0;
        repeat (2 * FRAME) tick();
        wait_slot_end(0);
        check("mrst_disp", 32'(seg_al), 32'hC0);

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rst = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 9) == 0);
            rv = 16'($urandom);
            value = rv >> (4 * $urandom_range(0, 4));
            dp_in = 4'($urandom);
            blank_lz = 1'($urandom);
            if (load && !rst)
                $display("load value=%h dp=%b blank_lz=%0d at %0t", value, dp_in, blank_lz, $time);
            tick();
        end
        rst = 1'b0;
        load = 1'b0;
        repeat (2 * FRAME) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
